tiny_fetch: RTL and testbench

//  Instruction-fetch stage of TinyCPU. Sits directly upstream of decode.

---
 rtl/tiny_fetch.sv | 128 ++++++++++++
 tb/tb_tiny_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_fetch.sv
// TinyCPU fetch stage: PC walker, imem req/ack handshake, small instruction FIFO.
// Optional FETCH_STALL_CNT_EN adds a saturating decode-stall cycle counter.
module tiny_fetch #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_FULL
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_next;
    logic [PW-1:0]       rd_q, rd_d;
    logic [PW-1:0]       wr_q, wr_d;
    logic [INSTR_W-1:0]  dat_q [DEPTH];
    logic [ADDR_W-1:0]   pcm_q [DEPTH];
    logic                push, pop;

    assign imem_req   = (state_q == S_REQ);
    assign imem_addr  = pc_q;
    assign inst_valid = (cnt_q != '0);
    assign inst_data  = dat_q[rd_q];
    assign inst_pc    = pcm_q[rd_q];

    // Redirect squashes both the returning word and any decode handshake.
    assign push     = imem_req & imem_ack & ~redirect;
    assign pop      = inst_valid & inst_ready & ~redirect;
    assign cnt_next = cnt_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_next;
        rd_d    = rd_q + PW'(pop);
        wr_d    = wr_q + PW'(push);
        if (redirect) begin
            state_d = S_IDLE;
            pc_d    = redirect_pc;
            cnt_d   = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (push) begin
                        pc_d = pc_q + 1'b1;
                        if (cnt_next == CW'(DEPTH))
                            state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (pop)
                        state_d = S_REQ;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
                pcm_q[i] <= '0;
            end
        end else if (push) begin
            dat_q[wr_q] <= imem_rdata;
            pcm_q[wr_q] <= pc_q;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q;

    assign stall_cnt = stall_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (inst_valid && !inst_ready && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tiny_fetch.sv
// Directed bench for tiny_fetch: streaming, backpressure, wait states,
// redirect flush, PC wrap, mid-run reset and the optional stall counter.
module tb_tiny_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_data;
    logic [7:0]  inst_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory model: each word encodes its own address.
    assign imem_rdata = {~imem_addr, imem_addr};

    tiny_fetch #(
        .ADDR_W  (8),
        .INSTR_W (16),
        .RESET_PC(0),
        .DEPTH   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] pc);
        logic [15:0] word;
        word = {~pc, pc};
        chk({tag, ".valid"}, 32'(inst_valid), 32'd1);
        chk({tag, ".pc"},    32'(inst_pc),    32'(pc));
        chk({tag, ".data"},  32'(inst_data),  32'(word));
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b1;
        inst_ready  = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        step();
        step();
        chk("rst.req",   32'(imem_req),   32'd0);
        chk("rst.addr",  32'(imem_addr),  32'd0);
        chk("rst.valid", 32'(inst_valid), 32'd0);
        chk("rst.data",  32'(inst_data),  32'd0);
        chk("rst.pc",    32'(inst_pc),    32'd0);

        // streaming at one instruction per cycle
        reset = 1'b0;
        step();
        chk("t1.req0",   32'(imem_req),   32'd1);
        chk("t1.addr0",  32'(imem_addr),  32'd0);
        chk("t1.valid0", 32'(inst_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk_head("t1.head", 8'(k));
            chk("t1.addr", 32'(imem_addr), 32'(k + 1));
            chk("t1.req",  32'(imem_req),  32'd1);
        end

        // decode backpressure fills the FIFO and stops requests
        inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2.req", 32'(imem_req), 32'd0);
            chk_head("t2.hold", 8'd5);
        end
        inst_ready = 1'b1;
        step();
        chk_head("t2.resume6", 8'd6);
        chk("t2.req",  32'(imem_req),  32'd1);
        chk("t2.addr", 32'(imem_addr), 32'd7);
        step();
        chk_head("t2.resume7", 8'd7);
        chk("t2.addr8", 32'(imem_addr), 32'd8);
        step();
        chk_head("t2.resume8", 8'd8);
        chk("t2.addr9", 32'(imem_addr), 32'd9);

        // three wait states on one request
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3.req",   32'(imem_req),   32'd1);
            chk("t3.addr",  32'(imem_addr),  32'd9);
            chk("t3.valid", 32'(inst_valid), 32'd0);
        end
        imem_ack = 1'b1;
        step();
        chk_head("t3.ack", 8'd9);
        chk("t3.addr10", 32'(imem_addr), 32'd10);
        imem_ack = 1'b0;
        step();
        chk("t3.onepush", 32'(inst_valid), 32'd0);
        chk("t3.hold10",  32'(imem_addr),  32'd10);

        // redirect with buffered data and a concurrent ack
        imem_ack   = 1'b1;
        inst_ready = 1'b0;
        step();
        chk_head("t4.fill10", 8'd10);
        step();
        chk("t4.full", 32'(imem_req), 32'd0);
        inst_ready = 1'b1;
        step();
        chk_head("t4.head11", 8'd11);
        chk("t4.req12", 32'(imem_addr), 32'd12);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        step();
        chk("t4.valid", 32'(inst_valid), 32'd0);
        chk("t4.idle",  32'(imem_req),   32'd0);
        chk("t4.pc",    32'(imem_addr),  32'h40);
        redirect = 1'b0;
        step();
        chk("t4.req",   32'(imem_req),   32'd1);
        chk("t4.addr",  32'(imem_addr),  32'h40);
        chk("t4.empty", 32'(inst_valid), 32'd0);
        step();
        chk_head("t4.first", 8'h40);

        // redirect from FULL, then PC wrap
        inst_ready = 1'b0;
        step();
        chk("t5.full", 32'(imem_req), 32'd0);
        chk_head("t5.hold", 8'h40);
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        inst_ready  = 1'b1;
        step();
        chk("t5.valid", 32'(inst_valid), 32'd0);
        chk("t5.addr",  32'(imem_addr),  32'hFE);
        redirect = 1'b0;
        step();
        chk("t5.req", 32'(imem_req), 32'd1);
        step();
        chk_head("t5.FE", 8'hFE);
        step();
        chk_head("t5.FF", 8'hFF);
        step();
        chk_head("t5.00", 8'h00);
        step();
        chk_head("t5.01", 8'h01);

        // reset while a request is outstanding and acked
        reset = 1'b1;
        step();
        chk("rst2.req",   32'(imem_req),   32'd0);
        chk("rst2.addr",  32'(imem_addr),  32'd0);
        chk("rst2.valid", 32'(inst_valid), 32'd0);
        chk("rst2.data",  32'(inst_data),  32'd0);
        chk("rst2.pc",    32'(inst_pc),    32'd0);
        reset = 1'b0;

`ifdef FETCH_STALL_CNT_EN
        chk("t6.clr", 32'(stall_cnt), 32'd0);
        step();
        step();
        chk_head("t6.head", 8'd0);
        inst_ready = 1'b0;
        repeat (10) step();
        chk("t6.ten", 32'(stall_cnt), 32'd10);
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        step();
        chk("t6.keep",  32'(stall_cnt),  32'd11);
        chk("t6.flush", 32'(inst_valid), 32'd0);
        redirect = 1'b0;
        step();
        step();
        chk("t6.idlecnt", 32'(stall_cnt), 32'd11);
        repeat (70000) step();
        chk("t6.sat", 32'(stall_cnt), 32'hFFFF);
        reset = 1'b1;
        step();
        chk("t6.rst", 32'(stall_cnt), 32'd0);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
